decode_cex_stage: RTL and testbench

Registered instruction-decode stage with a valid/ready handshake and conditional-execution (CEX) tracking. It sits between fetch and the execute/ALU datapath. It classifies each accepted instruction word into the processor's 4-bit opcode class and registers it into a single output slot. It also runs the CEX window state machine, which marks the following T/F instructions as executed or squashed. Field-level decoding (ALU op, offsets, immediates) stays downstream on `out_inst`.

---
 rtl/decode_cex_stage.sv | 170 +++++++++++++++++
 tb/tb_decode_cex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cex_stage.sv
// decode_cex_stage: single-slot registered decode stage with valid/ready
// handshake. Classifies each instruction into a 4-bit opcode class and tracks
// the conditional-execution (CEX) window, which marks the following
// T/F instructions as executed or squashed.
module decode_cex_stage #(
  parameter int WORD   = 16,
  parameter bit CEX_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [WORD-1:0] inst,
  output logic            inst_ready,
  output logic [3:0]      cex_cond,
  input  logic            cond_met,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_inst,
  output logic [3:0]      out_opcode,
  output logic            out_squash,
  output logic            cex_active
);

  // Opcode class codes shared with the execute datapath.
  localparam logic [3:0] OP_BL    = 4'd0;
  localparam logic [3:0] OP_BC    = 4'd1;
  localparam logic [3:0] OP_ALU   = 4'd2;
  localparam logic [3:0] OP_SHIFT = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_SVC   = 4'd7;
  localparam logic [3:0] OP_CEX   = 4'd8;
  localparam logic [3:0] OP_MOVI  = 4'd9;
  localparam logic [3:0] OP_LDR   = 4'd10;
  localparam logic [3:0] OP_STR   = 4'd11;

  // CEX window states.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRUE_PH  = 2'd1;
  localparam logic [1:0] FALSE_PH = 2'd2;

  logic            out_valid_q,  out_valid_d;
  logic [WORD-1:0] out_inst_q,   out_inst_d;
  logic [3:0]      out_opcode_q, out_opcode_d;
  logic            out_squash_q, out_squash_d;
  logic [1:0]      state_q,      state_d;
  logic [2:0]      t_cnt_q,      t_cnt_d;
  logic [2:0]      f_cnt_q,      f_cnt_d;
  logic            take_t_q,     take_t_d;

  logic       accept;
  logic [3:0] dec_opcode;
  logic       is_cex;
  logic       win_squash;
  logic       restart;

  assign inst_ready = !flush && (!out_valid_q || out_ready);
  assign accept     = inst_valid && inst_ready;
  assign cex_cond   = inst[9:6];

  // Classify the offered word into its opcode class.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dec_opcode = OP_ALU;
    unique case (inst[15:14])
      2'b00: dec_opcode = inst[13] ? OP_BC : OP_BL;
      2'b10: dec_opcode = OP_LDR;
      2'b11: dec_opcode = OP_STR;
      default: begin
        if (inst[13]) begin
          dec_opcode = OP_MOVI;
        end else if (!inst[12]) begin
          if (inst[11:8] == 4'b1100)      dec_opcode = OP_SWAP;
          else if (inst[11:8] == 4'b1101) dec_opcode = OP_SHIFT;
          else                            dec_opcode = OP_ALU;
        end else begin
          unique case (inst[11:10])
            2'b00:   dec_opcode = OP_LOAD;
            2'b01:   dec_opcode = OP_STORE;
            2'b10:   dec_opcode = OP_SVC;
            default: dec_opcode = OP_CEX;
          endcase
        end
      end
    endcase
  end

  // Squash decision for the offered word and next-state of slot and window.
  always_comb begin
    is_cex = CEX_EN && (dec_opcode == OP_CEX);

    // Inside a window the phase decides; a CEX that survives restarts it.
    unique case (state_q)
      TRUE_PH:  win_squash = !take_t_q;
      FALSE_PH: win_squash = take_t_q;
      default:  win_squash = 1'b0;
    endcase
    restart = is_cex && !win_squash;

    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_opcode_d = out_opcode_q;
    out_squash_d = out_squash_q;
    state_d      = state_q;
    t_cnt_d      = t_cnt_q;
    f_cnt_d      = f_cnt_q;
    take_t_d     = take_t_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_inst_d   = inst;
      out_opcode_d = dec_opcode;
      out_squash_d = (state_q == IDLE) ? is_cex : win_squash;
      if (restart) begin
        take_t_d = cond_met;
        t_cnt_d  = inst[5:3];
        f_cnt_d  = inst[2:0];
        if (inst[5:3] != 3'd0)      state_d = TRUE_PH;
        else if (inst[2:0] != 3'd0) state_d = FALSE_PH;
        else                        state_d = IDLE;
      end else if (state_q == TRUE_PH) begin
        t_cnt_d = t_cnt_q - 3'd1;
        if (t_cnt_q == 3'd1) state_d = (f_cnt_q != 3'd0) ? FALSE_PH : IDLE;
      end else if (state_q == FALSE_PH) begin
        f_cnt_d = f_cnt_q - 3'd1;
        if (f_cnt_q == 3'd1) state_d = IDLE;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Register slot and window state; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_opcode_q <= 4'd0;
      out_squash_q <= 1'b0;
      state_q      <= IDLE;
      t_cnt_q      <= 3'd0;
      f_cnt_q      <= 3'd0;
      take_t_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_opcode_q <= out_opcode_d;
      out_squash_q <= out_squash_d;
      state_q      <= state_d;
      t_cnt_q      <= t_cnt_d;
      f_cnt_q      <= f_cnt_d;
      take_t_q     <= take_t_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_opcode = out_opcode_q;
  assign out_squash = out_squash_q;
  assign cex_active = (state_q != IDLE);

endmodule

// File: tb/tb_decode_cex_stage.sv
// Scoreboard bench for decode_cex_stage: the driver pushes hand-computed
// expectations on each accept, the monitor pops and compares on consume.
module tb_decode_cex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic [3:0]  cex_cond;
  logic        cond_met;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [3:0]  out_opcode;
  logic        out_squash;
  logic        cex_active;

  // Second build with CEX tracking disabled.
  logic        n_inst_valid;
  logic [15:0] n_inst;
  logic        n_inst_ready;
  logic [3:0]  n_cex_cond;
  logic        n_cond_met;
  logic        n_out_valid;
  logic [15:0] n_out_inst;
  logic [3:0]  n_out_opcode;
  logic        n_out_squash;
  logic        n_cex_active;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [15:0] w;
    logic [3:0]  op;
    logic        sq;
    logic        act;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  decode_cex_stage #(.WORD(16), .CEX_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .cex_cond(cex_cond), .cond_met(cond_met),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_opcode(out_opcode), .out_squash(out_squash),
    .cex_active(cex_active)
  );

  decode_cex_stage #(.WORD(16), .CEX_EN(1'b0)) u_dut_nocex (
    .clk(clk), .rst(rst), .inst_valid(n_inst_valid), .inst(n_inst),
    .inst_ready(n_inst_ready), .cex_cond(n_cex_cond), .cond_met(n_cond_met),
    .flush(1'b0), .out_valid(n_out_valid), .out_ready(1'b1),
    .out_inst(n_out_inst), .out_opcode(n_out_opcode),
    .out_squash(n_out_squash), .cex_active(n_cex_active)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one word, wait (bounded) for accept, push the expectation.
  task automatic send(input logic [15:0] w, input logic cm, input logic [3:0] op,
                      input logic sq, input logic act);
    int  n    = 0;
    bit  done = 1'b0;
    exp_t e;
    inst_valid = 1'b1;
    inst       = w;
    cond_met   = cm;
    while (!done && n < 20) begin
      @(negedge clk);
      if (inst_ready) done = 1'b1;
      @(posedge clk);
      n++;
    end
    if (done) begin
      e.w = w; e.op = op; e.sq = sq; e.act = act;
      sb.push_back(e);
    end else begin
      check("accept_timeout", 0, 1);
    end
    #1;
    inst_valid = 1'b0;
    cond_met   = 1'b0;
    if (done) begin
      check("latency_valid", out_valid, 1);
      check("latency_inst", out_inst, w);
    end
  endtask

  // Monitor: compare whatever the slot presents when it is consumed.
  always @(negedge clk) begin
    if (out_valid && (flush || rst)) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 0, 1);
      end else begin
        mon_e = sb.pop_front();
        check("out_inst", out_inst, mon_e.w);
        check("out_opcode", out_opcode, mon_e.op);
        check("out_squash", out_squash, mon_e.sq);
        check("cex_active", cex_active, mon_e.act);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = '0; cond_met = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    n_inst_valid = 1'b0; n_inst = '0; n_cond_met = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_opcode", out_opcode, 0);
    check("rst_out_squash", out_squash, 0);
    check("rst_cex_active", cex_active, 0);
    rst = 1'b0;

    // cex_cond is a combinational view of inst[9:6].
    inst = 16'h5DC0;
    #1 check("cex_cond", cex_cond, 4'h7);

    // Opcode sweep.
    send(16'h0000, 0, 4'd0, 0, 0);
    send(16'h2000, 0, 4'd1, 0, 0);
    send(16'h4000, 0, 4'd2, 0, 0);
    send(16'h4C00, 0, 4'd4, 0, 0);
    send(16'h4D00, 0, 4'd3, 0, 0);
    send(16'h5000, 0, 4'd5, 0, 0);
    send(16'h5400, 0, 4'd6, 0, 0);
    send(16'h5800, 0, 4'd7, 0, 0);
    send(16'h5C00, 0, 4'd8, 1, 0);
    send(16'h6000, 0, 4'd9, 0, 0);
    send(16'h8000, 0, 4'd10, 0, 0);
    send(16'hC000, 0, 4'd11, 0, 0);

    // CEX T=2 F=1, condition true.
    send(16'h5C11, 1, 4'd8, 1, 1);
    send(16'h4000, 0, 4'd2, 0, 1);
    send(16'h4000, 0, 4'd2, 0, 1);
    send(16'h4000, 0, 4'd2, 1, 0);
    send(16'h4000, 0, 4'd2, 0, 0);

    // Same, condition false.
    send(16'h5C11, 0, 4'd8, 1, 1);
    send(16'h4000, 0, 4'd2, 1, 1);
    send(16'h4000, 0, 4'd2, 1, 1);
    send(16'h4000, 0, 4'd2, 0, 0);
    send(16'h4000, 0, 4'd2, 0, 0);

    // CEX T=3 F=0, backpressure then flush mid-window.
    send(16'h5C18, 1, 4'd8, 1, 1);
    send(16'h4001, 0, 4'd2, 0, 1);
    out_ready  = 1'b0;
    inst_valid = 1'b1;
    inst       = 16'h4002;
    repeat (3) begin
      @(negedge clk);
      check("stall_inst_ready", inst_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_inst", out_inst, 16'h4001);
      check("stall_cex_active", cex_active, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'h4002, 0, 4'd2, 0, 1);
    out_ready = 1'b0;
    flush     = 1'b1;
    #1 check("flush_inst_ready", inst_ready, 0);
    @(posedge clk);
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_cex_active", cex_active, 0);
    flush     = 1'b0;
    out_ready = 1'b1;
    send(16'h4003, 0, 4'd2, 0, 0);

    // Nested CEX restarts the window.
    send(16'h5C10, 1, 4'd8, 1, 1);
    send(16'h5C08, 0, 4'd8, 0, 1);
    send(16'h4000, 0, 4'd2, 1, 0);
    send(16'h4000, 0, 4'd2, 0, 0);

    // Reset mid-window with a full slot.
    send(16'h5C18, 1, 4'd8, 1, 1);
    send(16'h4004, 0, 4'd2, 0, 1);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_inst", out_inst, 0);
    check("mrst_out_opcode", out_opcode, 0);
    check("mrst_out_squash", out_squash, 0);
    check("mrst_cex_active", cex_active, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    send(16'h4005, 0, 4'd2, 0, 0);

    // CEX_EN=0 build: CEX is an ordinary instruction.
    n_inst_valid = 1'b1;
    n_inst       = 16'h5C11;
    n_cond_met   = 1'b1;
    @(posedge clk);
    #1;
    check("nocex_ready", n_inst_ready, 1);
    check("nocex_valid", n_out_valid, 1);
    check("nocex_op0", n_out_opcode, 4'd8);
    check("nocex_sq0", n_out_squash, 0);
    check("nocex_act0", n_cex_active, 0);
    n_cond_met = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_inst = 16'h4000;
      @(posedge clk);
      #1;
      check("nocex_op", n_out_opcode, 4'd2);
      check("nocex_inst", n_out_inst, 16'h4000);
      check("nocex_sq", n_out_squash, 0);
      check("nocex_act", n_cex_active, 0);
    end
    n_inst_valid = 1'b0;
    check("nocex_cond", n_cex_cond, 4'h0);

    // Drain the scoreboard (bounded).
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
